uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
- Downstream consumer of the sample FIFO (`queue`): pops one word whenever the FIFO is non-empty and serializes it as an asynchronous UART frame on `tx`.
- Frame format: start bit, NBITS data bits LSB-first, optional parity bit, one stop bit.
- Sits between the acquisition buffer and the host serial link.
- Drives the FIFO's `pp` input and reads its registered `out` and `em` signals.

Parameters:
- NBITS, 8, data word width; must match the FIFO NBITS.
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); minimum 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- ck  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  transmit enable; sampled only in IDLE.
- em  in  1  FIFO empty flag.
- q_data  in  NBITS  FIFO registered read data (`out`).
- pp  out  1  FIFO pop strobe; registered; high exactly one cycle per frame.
- tx  out  1  serial line; registered; idle level 1.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (async, rst_n=0): state IDLE, tx=1, pp=0, busy=0, done=0, baud counter=0, bit index=0, shift register=0.
- On rst_n release, first active edge is evaluated from IDLE.
- FSM states: IDLE, POP, WAIT, START, DATA, PAR, STOP.
- IDLE: if en=1 and em=0 at an edge, then pp<=1 and go to POP; otherwise stay, tx=1.
- POP: pp is high this cycle (the FIFO updates `out` at the closing edge); at the edge, pp<=0 and go to WAIT.
- WAIT: q_data is now valid; at the edge, shift<=q_data, tx<=0, counter<=CLK_DIV-1, go to START.
- Latency: pp rising to tx falling is exactly 2 clocks.
- Parity is computed from the captured word at the WAIT edge.
- Every bit (START, each DATA bit, PAR, STOP) holds tx for exactly CLK_DIV cycles.
  - The counter decrements each cycle; the bit ends on the edge where counter==0.
  - At that edge the counter reloads to CLK_DIV-1 and tx takes the next bit's value.
- START -> DATA: tx<=shift[0].
- DATA:
  - On bit end, shift right.
  - Bit index 0..NBITS-1; after bit NBITS-1, go to PAR if PARITY!=0, else STOP.
  - Entering PAR drives tx<=parity bit; entering STOP drives tx<=1.
- Parity bit value:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- STOP:
  - done=1 during the final cycle (counter==0).
  - At the bit end, go to IDLE with tx=1.
- Back-to-back frames: tx stays high for CLK_DIV+3 cycles between the end of the last data/parity bit and the next start bit (STOP plus IDLE, POP, WAIT).
- en deasserted mid-frame: the current frame completes normally, and no further pop occurs until en=1.
- em rising during POP/WAIT is ignored; the pop has already been issued.
- No second pp is issued until the state returns to IDLE, so the FIFO can never be popped twice per frame.
- PARITY values other than 0/1/2 behave as 0.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is truncated. Any word already popped is lost; this is accepted behaviour.

Test Plan:
- CLK_DIV=4, PARITY=0: FIFO preloaded with 0xA5, en=1.
  -> pp pulses 1 cycle; tx low 2 clocks later.
  -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  -> done pulses once; busy spans 2+40 cycles; em=1 after.
- Empty FIFO, en=1 for 100 cycles -> pp never asserts; tx=1; busy=0.
- PARITY=1 with 0x07, then PARITY=2 with 0x07 -> parity bit is 1 (even) and 0 (odd); frame length 11 bits = 44 cycles.
- Three words 0x01, 0x02, 0x03 queued -> three frames in order, each separated by exactly CLK_DIV+3=7 high cycles after the last data bit; exactly three pp pulses.
- en dropped during DATA of frame 1, with 2 words queued -> frame 1 completes; no pp until en returns; then frame 2 is sent.
- rst_n asserted mid-DATA -> tx=1, pp=0, busy=0 immediately (same cycle, asynchronous).
  -> After release with FIFO non-empty and en=1: first pp 1 edge later; a clean frame follows.

Source files
------------

// File: rtl/uart_tx_drain.sv
// FIFO drain: pops one word whenever the FIFO has data and sends it as a UART frame
// (start, NBITS data bits LSB-first, optional parity, one stop bit).
module uart_tx_drain #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned PARITY  = 0
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             en,
  input  logic             em,
  input  logic [NBITS-1:0] q_data,
  output logic             pp,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             pp_q, pp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  // State and datapath registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      pp_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      pp_q    <= pp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pp_d    = 1'b0;
    bit_end = (cnt_q == '0);

    // Every serial bit, including stop, shares one reloading baud counter
    if (state_q == S_START || state_q == S_DATA || state_q == S_PAR || state_q == S_STOP) begin
      cnt_d = bit_end ? CNT_MAX : cnt_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (en && !em) begin
          pp_d    = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        shift_d = q_data;
        par_d   = ODD_PAR ? ~(^q_data) : ^q_data;
        tx_d    = 1'b0;
        cnt_d   = CNT_MAX;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            if (HAS_PAR) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == '0);
  end

  assign pp   = pp_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO models feed three instances (no/even/odd parity);
// frames are compared cycle by cycle against waveforms built from the frame rules.
module tb_uart_tx_drain;
  localparam int unsigned NB   = 8;
  localparam int unsigned CDIV = 4;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, en_p = 1'b0;
  logic          em = 1'b1, em_p = 1'b1;
  logic [NB-1:0] q_data = '0, qd_p = '0;
  logic          pp, tx, busy, done;
  logic          pp_e, tx_e, busy_e, done_e;
  logic          pp_o, tx_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;
  int pp_total = 0;
  logic [NB-1:0] fq[$];
  logic [NB-1:0] pq[$];

  logic [63:0] txs[3];
  int busy_hi[3], done_hi[3], done_at[3], pp_hi[3], pre_hi[3], waited[3];

  uart_tx_drain #(.NBITS(NB), .CLK_DIV(CDIV), .PARITY(0)) dut (
    .ck(ck), .rst_n(rst_n), .en(en), .em(em), .q_data(q_data),
    .pp(pp), .tx(tx), .busy(busy), .done(done));
  uart_tx_drain #(.NBITS(NB), .CLK_DIV(CDIV), .PARITY(1)) dut_e (
    .ck(ck), .rst_n(rst_n), .en(en_p), .em(em_p), .q_data(qd_p),
    .pp(pp_e), .tx(tx_e), .busy(busy_e), .done(done_e));
  uart_tx_drain #(.NBITS(NB), .CLK_DIV(CDIV), .PARITY(2)) dut_o (
    .ck(ck), .rst_n(rst_n), .en(en_p), .em(em_p), .q_data(qd_p),
    .pp(pp_o), .tx(tx_o), .busy(busy_o), .done(done_o));

  always #5 ck = ~ck;

  // Registered-output FIFO models: data and empty flag update on the popping edge
  always @(posedge ck) begin
    if (pp && fq.size() != 0) q_data <= fq.pop_front();
    em <= (fq.size() == 0);
  end
  always @(posedge ck) begin
    if (pp_e && pq.size() != 0) qd_p <= pq.pop_front();
    em_p <= (pq.size() == 0);
  end
  always @(negedge ck) if (pp) pp_total++;

  function automatic logic tx_of(input int s);
    return (s == 0) ? tx : ((s == 1) ? tx_e : tx_o);
  endfunction
  function automatic logic pp_of(input int s);
    return (s == 0) ? pp : ((s == 1) ? pp_e : pp_o);
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? busy : ((s == 1) ? busy_e : busy_o);
  endfunction
  function automatic logic done_of(input int s);
    return (s == 0) ? done : ((s == 1) ? done_e : done_o);
  endfunction

  // Reference: per-cycle tx waveform from frame start, plus one trailing idle cycle
  function automatic logic [63:0] exp_wave(input logic [NB-1:0] w, input int mode);
    logic [15:0] f;
    logic [63:0] wave;
    int n;
    f = '0;
    wave = '0;
    f[0] = 1'b0;
    for (int i = 0; i < NB; i++) f[1+i] = w[i];
    n = NB + 1;
    if (mode == 1 || mode == 2) begin
      f[n] = (($countones(w) % 2) == 1) ^ (mode == 2);
      n = n + 1;
    end
    f[n] = 1'b1;
    n = n + 1;
    for (int k = 0; k < n * CDIV; k++) wave[k] = f[k / CDIV];
    wave[n * CDIV] = 1'b1;
    return wave;
  endfunction

  // Waits for a pop, then records the frame waveform and activity counts
  task automatic capture(input int s, input int nbits, output bit ok);
    int total;
    total = nbits * CDIV;
    ok = 1'b0;
    waited[s] = 0; busy_hi[s] = 0; done_hi[s] = 0; done_at[s] = -1;
    pp_hi[s] = 0; pre_hi[s] = 0; txs[s] = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge ck);
      waited[s]++;
      if (pp_of(s)) ok = 1'b1;
    end
    if (!ok) return;
    busy_hi[s] += int'(busy_of(s));
    pre_hi[s]  += int'(tx_of(s));
    @(negedge ck);
    pp_hi[s]   += int'(pp_of(s));
    busy_hi[s] += int'(busy_of(s));
    pre_hi[s]  += int'(tx_of(s));
    for (int k = 0; k <= total; k++) begin
      @(negedge ck);
      txs[s][k] = tx_of(s);
      pp_hi[s]   += int'(pp_of(s));
      busy_hi[s] += int'(busy_of(s));
      if (done_of(s)) begin
        done_hi[s]++;
        done_at[s] = k;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ck);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (pp !== 1'b0) begin errors++; $display("FAIL reset_pp got %b want 0", pp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    logic [63:0] e;
    fq.push_back(8'hA5);
    en = 1'b1;
    capture(0, 10, ok);
    e = exp_wave(8'hA5, 0);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout no pp"); end
    checks++; if (txs[0] !== e) begin errors++; $display("FAIL single_wave got %h want %h", txs[0], e); end
    checks++; if (pre_hi[0] != 2 || pp_hi[0] != 0) begin errors++;
      $display("FAIL single_pp_latency tx_high_pre %0d pp_extra %0d want 2 0", pre_hi[0], pp_hi[0]); end
    checks++; if (busy_hi[0] != 42) begin errors++; $display("FAIL single_busy got %0d want 42", busy_hi[0]); end
    checks++; if (done_hi[0] != 1 || done_at[0] != 39) begin errors++;
      $display("FAIL single_done count %0d at %0d want 1 at 39", done_hi[0], done_at[0]); end
    checks++; if (em !== 1'b1) begin errors++; $display("FAIL single_em got %b want 1", em); end
  endtask

  task automatic test_empty();
    int bad;
    bad = 0;
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ck);
      if (pp !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_idle bad_cycles %0d want 0", bad); end
  endtask

  task automatic test_parity();
    bit ok1, ok2;
    logic [NB-1:0] w;
    logic [63:0] ee, eo;
    en_p = 1'b1;
    for (int it = 0; it < 5; it++) begin
      w = (it == 0) ? 8'h07 : NB'($urandom_range(0, 255));
      pq.push_back(w);
      fork
        capture(1, 11, ok1);
        capture(2, 11, ok2);
      join
      ee = exp_wave(w, 1);
      eo = exp_wave(w, 2);
      checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL parity_timeout even %0d odd %0d", ok1, ok2); end
      checks++; if (txs[1] !== ee) begin errors++; $display("FAIL parity_even w=%h got %h want %h", w, txs[1], ee); end
      checks++; if (txs[2] !== eo) begin errors++; $display("FAIL parity_odd w=%h got %h want %h", w, txs[2], eo); end
      if (it == 0) begin
        checks++; if (txs[1][36] !== 1'b1 || txs[2][36] !== 1'b0) begin errors++;
          $display("FAIL parity_bit_07 even %b odd %b want 1 0", txs[1][36], txs[2][36]); end
        checks++; if (done_at[1] != 43 || done_hi[2] != 1) begin errors++;
          $display("FAIL parity_len done_at %0d odd_done %0d want 43 1", done_at[1], done_hi[2]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    logic [NB-1:0] w;
    logic [63:0] e;
    en = 1'b0;
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    repeat (3) @(negedge ck);
    base = pp_total;
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture(0, 10, ok);
      w = NB'(f + 1);
      e = exp_wave(w, 0);
      checks++; if (!ok || txs[0] !== e) begin errors++; $display("FAIL b2b_frame%0d got %h want %h", f, txs[0], e); end
      if (f > 0) begin
        checks++; if (waited[0] != 1 || pre_hi[0] != 2) begin errors++;
          $display("FAIL b2b_gap%0d wait %0d pre_high %0d want 1 2", f, waited[0], pre_hi[0]); end
      end
    end
    repeat (20) @(negedge ck);
    checks++; if (pp_total - base != 3) begin errors++; $display("FAIL b2b_pops got %0d want 3", pp_total - base); end
  endtask

  task automatic test_en_drop();
    bit ok;
    int extra;
    logic [NB-1:0] w0, w1;
    logic [63:0] e;
    w0 = NB'($urandom_range(0, 255));
    w1 = NB'($urandom_range(0, 255));
    en = 1'b0;
    fq.push_back(w0); fq.push_back(w1);
    repeat (3) @(negedge ck);
    en = 1'b1;
    fork
      capture(0, 10, ok);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge ck);
          if (pp) break;
        end
        repeat (12) @(negedge ck);
        en = 1'b0;
      end
    join
    e = exp_wave(w0, 0);
    checks++; if (!ok || txs[0] !== e) begin errors++; $display("FAIL endrop_frame1 got %h want %h", txs[0], e); end
    extra = pp_total;
    repeat (60) @(negedge ck);
    checks++; if (pp_total != extra || em !== 1'b0) begin errors++;
      $display("FAIL endrop_hold pops %0d em %b want 0 0", pp_total - extra, em); end
    en = 1'b1;
    capture(0, 10, ok);
    e = exp_wave(w1, 0);
    checks++; if (!ok || txs[0] !== e) begin errors++; $display("FAIL endrop_frame2 got %h want %h", txs[0], e); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [NB-1:0] w1;
    logic [63:0] e;
    w1 = NB'($urandom_range(1, 255));
    en = 1'b1;
    fq.push_back(8'h00); fq.push_back(w1);
    for (int i = 0; i < 400; i++) begin
      @(negedge ck);
      if (pp) break;
    end
    repeat (15) @(negedge ck);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || pp !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_async tx %b pp %b busy %b want 1 0 0", tx, pp, busy); end
    repeat (2) @(negedge ck);
    #1 rst_n = 1'b1;
    capture(0, 10, ok);
    e = exp_wave(w1, 0);
    checks++; if (!ok || waited[0] != 1) begin errors++; $display("FAIL rstmid_first_pp wait %0d want 1", waited[0]); end
    checks++; if (txs[0] !== e) begin errors++; $display("FAIL rstmid_frame got %h want %h", txs[0], e); end
  endtask

  task automatic test_random();
    bit ok;
    logic [NB-1:0] w;
    logic [63:0] e;
    en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      w = NB'($urandom_range(0, 255));
      fq.push_back(w);
      capture(0, 10, ok);
      e = exp_wave(w, 0);
      checks++; if (!ok || txs[0] !== e || done_hi[0] != 1) begin errors++;
        $display("FAIL random_frame w=%h got %h want %h done %0d", w, txs[0], e, done_hi[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_parity();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
    repeat (5) @(negedge ck);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
